aes_decipher: RTL and testbench

Iterative AES inverse cipher core: one inverse round per clock, 128-bit block, AES-128 (10 rounds) and AES-256 (14 rounds). It mirrors `AES_encipher` and uses the same handshake and externally supplied round-key interface. The core drives `round` to index the key schedule memory and consumes `round_key` in descending order, Nr down to 0. It sits beside `AES_encipher`, sharing the key-expansion storage.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_inv_sbox.sv | 33 +++
 rtl/aes_decipher.sv | 105 ++++++++++
 tb/tb_aes_decipher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, core FSM encoding and the GF(2^8)
// helpers used by the inverse round datapath.
package aes_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_t;

  function automatic logic [3:0] num_rounds(input logic kl);
    return kl ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; constant operands fold to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
            inv_mix_column(s[63:32]),   inv_mix_column(s[31:0])};
  endfunction

  // Byte 0 sits in [127:120], column-major: byte index = row + 4*col.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by the
// multiplicative inverse in GF(2^8), computed as x^254 (0 maps to 0).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  logic [7:0] pre;
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;

  always_comb begin
    pre = '0;
    for (int i = 0; i < 8; i++) begin
      pre[i] = data[(i+2)%8] ^ data[(i+5)%8] ^ data[(i+7)%8];
    end
    pre = pre ^ 8'h05;
  end

  // Addition chain for 254 = 240 + 12 + 2.
  assign x2   = gf_mul(pre, pre);
  assign x3   = gf_mul(x2, pre);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign sub  = gf_mul(gf_mul(x240, x12), x2);

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128/256 inverse cipher, one inverse round per clock, with
// round keys fetched from an external schedule indexed by the round output.
module aes_decipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  aes_state_t   state_reg, state_next;
  logic [3:0]   round_reg, round_next;
  logic [127:0] block_reg, block_next;
  logic         keylen_reg, keylen_next;
  logic [127:0] new_block_reg, new_block_next;
  logic         ready_reg, ready_next;

  logic [127:0] shifted, subbed, keyed, mixed;

  assign shifted = inv_shift_rows(new_block_reg);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_inv_sbox u_inv_sbox (
        .data (shifted[127-8*gi -: 8]),
        .sub  (subbed[127-8*gi -: 8])
      );
    end
  endgenerate

  assign keyed = subbed ^ round_key;
  assign mixed = inv_mix_columns(keyed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      round_reg     <= '0;
      block_reg     <= '0;
      keylen_reg    <= 1'b0;
      new_block_reg <= '0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      round_reg     <= round_next;
      block_reg     <= block_next;
      keylen_reg    <= keylen_next;
      new_block_reg <= new_block_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (next) state_next = ST_INIT;
      ST_INIT:          state_next = ST_ROUND;
      ST_ROUND:         if (round_reg == 4'd0) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    round_next     = round_reg;
    block_next     = block_reg;
    keylen_next    = keylen_reg;
    new_block_next = new_block_reg;
    ready_next     = ready_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (next) begin
          block_next  = block;
          keylen_next = keylen;
          round_next  = num_rounds(keylen);
          ready_next  = 1'b0;
        end
      end
      ST_INIT: begin
        new_block_next = block_reg ^ round_key;
        round_next     = num_rounds(keylen_reg) - 4'd1;
      end
      ST_ROUND: begin
        // The last round skips InvMixColumns and parks the core in DONE.
        if (round_reg == 4'd0) begin
          new_block_next = keyed;
          ready_next     = 1'b1;
        end else begin
          new_block_next = mixed;
          round_next     = round_reg - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign round     = round_reg;
  assign new_block = new_block_reg;
  assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher.sv
// Bench for aes_decipher: forward-AES reference model builds ciphertexts and
// key schedules; a per-cycle monitor checks round, ready and plaintext.
module tb_aes_decipher;

  typedef logic [15:0][127:0] sched_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  sched_t       ks;
  logic [127:0] stim_plain;
  logic [7:0]   sbox_t [256];
  bit           tables_ready = 1'b0;
  int           wd_hits = 0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  assign round_key = ks[round];

  aes_decipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  function automatic logic [7:0] xt8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] q, input int n);
    logic [15:0] d;
    d = {q, q} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt8(a0) ^ xt8(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt8(a1) ^ xt8(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt8(a2) ^ xt8(a3) ^ a3,
                           xt8(a0) ^ a0 ^ a1 ^ a2 ^ xt8(a3)};
    end
    return o;
  endfunction

  // AES-128 keys occupy key[255:128]; AES-256 keys use all 256 bits.
  function automatic sched_t expand(input logic [255:0] key, input bit kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nw;
    sched_t s;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rc = 8'h01;
    s  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt8(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < nw / 4; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input sched_t s, input int nr);
    logic [127:0] st;
    st = pt ^ s[0];
    for (int r = 1; r < nr; r++) st = mix_columns(shift_rows(sub_bytes(st))) ^ s[r];
    return shift_rows(sub_bytes(st)) ^ s[nr];
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // Monitor: builds the S-box, pins the model, then tracks each accepted
  // operation as "edges since accept" and checks the outputs every cycle.
  initial begin : compare
    logic [7:0]   p, q, x;
    sched_t       s;
    int           t, nr_m, exp_round, wd_seen;
    bit           have_op;
    logic [127:0] plain_m;

    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;

    chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    s = expand(KEY_B, 1'b0);
    chk("model_key10_B", s[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_enc_B", encrypt(PT_B, s, 10), CT_B);
    chk("model_enc_C1", encrypt(PT_C, expand(KEY_C1, 1'b0), 10), CT_C1);
    chk("model_enc_C3", encrypt(PT_C, expand(KEY_C3, 1'b1), 14), CT_C3);
    tables_ready = 1'b1;

    t = 0; nr_m = 10; have_op = 1'b0; plain_m = '0; wd_seen = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        have_op = 1'b0;
        t = 0;
      end else if (next && !(have_op && t <= nr_m + 1)) begin
        have_op = 1'b1;
        t       = 1;
        nr_m    = keylen ? 14 : 10;
        plain_m = stim_plain;
      end else if (have_op && t <= nr_m + 1) begin
        t++;
      end

      @(negedge clk);
      if (!rst_n) begin
        have_op = 1'b0;
        t = 0;
      end
      if (!have_op) begin
        chk("idle_round", 128'(round), 128'h0);
        chk("idle_ready", 128'(ready), 128'h0);
        chk("idle_new_block", new_block, 128'h0);
      end else begin
        exp_round = (t <= nr_m + 1) ? nr_m - (t - 1) : 0;
        chk("round", 128'(round), 128'(exp_round));
        chk("ready", 128'(ready), 128'(t == nr_m + 2));
        if (t == nr_m + 2) chk("plaintext", new_block, plain_m);
      end
      if (wd_hits != wd_seen) begin
        chk("wait_bound", 128'(wd_hits), 128'(wd_seen));
        wd_seen = wd_hits;
      end
    end
  end

  task automatic run_op(input logic [255:0] key, input bit kl, input logic [127:0] pt,
                        input logic [127:0] ct, input bit dis);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    ks = expand(key, kl);
    stim_plain = pt;
    block  = ct;
    keylen = kl;
    next   = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      if (dis) begin
        next   = 1'($urandom);
        block  = rand128();
        keylen = 1'($urandom);
      end
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    next = 1'b0;
    if (!seen) wd_hits++;
  endtask

  initial begin : driver
    logic [255:0] key;
    logic [127:0] pt;
    bit           kl;
    int           hits;
    next = 1'b0; keylen = 1'b0; block = '0; ks = '0; stim_plain = '0;
    #1 rst_n = 1'b0;
    wait (tables_ready);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(KEY_B, 1'b0, PT_B, CT_B, 1'b0);
    run_op(KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);
    run_op(KEY_C3, 1'b1, PT_C, CT_C3, 1'b0);

    // Abort mid-operation, with next held high across the reset edges.
    @(posedge clk); #1;
    ks = expand(KEY_C1, 1'b0); stim_plain = PT_C; block = CT_C1; keylen = 1'b0; next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    for (int i = 0; i < 20 && round != 4'd5; i++) begin
      @(posedge clk); #1;
    end
    if (round != 4'd5) wd_hits++;
    rst_n = 1'b0;
    next  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    next  = 1'b0;
    rst_n = 1'b1;
    run_op(KEY_C1, 1'b0, PT_C, CT_C1, 1'b0);

    // Back-to-back: next stays high through DONE for a second run.
    @(posedge clk); #1;
    ks = expand(KEY_C1, 1'b0); stim_plain = PT_C; block = CT_C1; keylen = 1'b0; next = 1'b1;
    @(posedge clk); #1;
    hits = 0;
    for (int i = 0; i < 40 && hits < 2; i++) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    next = 1'b0;
    if (hits < 2) wd_hits++;

    for (int n = 0; n < 100; n++) begin
      for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
      kl = 1'($urandom);
      pt = rand128();
      run_op(key, kl, pt, encrypt(pt, expand(key, kl), kl ? 14 : 10), (n % 3) == 0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
